// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch front-end bus: imem port, redirect, enable and decode stream
interface ifetch_queue_if;
  logic        fetch_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  // Fetch unit side: drives the ROM address and the decode stream.
  modport master (
    input  fetch_en,
    output imem_pc,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst
  );

  // Environment side: ROM, branch unit and decode.
  modport slave (
    output fetch_en,
    input  imem_pc,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end: PC owner, imem driver, {pc,inst} FIFO to decode
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic pop;
  logic push;

  // Handshake decode; a full queue still accepts a push when the head leaves the same cycle.
  always_comb begin
    pop  = bus.out_valid & bus.out_ready;
    push = bus.fetch_en & ~bus.redirect_valid & ((count < FULL_COUNT) | pop);
  end

  // ROM address and head-of-queue outputs come straight from registers.
  always_comb begin
    bus.imem_pc   = fetch_pc;
    bus.out_valid = (count != '0);
    bus.out_pc    = pc_mem[rd_ptr];
    bus.out_inst  = inst_mem[rd_ptr];
  end

  // PC, pointers and occupancy; a redirect flushes everything and retargets the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~32'd3;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= bus.imem_inst;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bench ROM: mem[pc>>2] = pc ^ 0xA5A5_0000.
  assign bus.imem_inst = bus.imem_pc ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_inst"}, bus.out_inst, pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n              = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    // Reset state
    #3;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_inst", bus.out_inst, 32'd0);
    check("rst_imem_pc", bus.imem_pc, 32'd0);

    // Streaming
    @(negedge clk);
    rst_n         = 1'b1;
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("stream%0d", i), 32'(i * 4));
    end
    check("stream_imem_pc", bus.imem_pc, 32'h10);

    // Backpressure from a clean queue (redirect to 0 with decode stalled)
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    tick();
    check("bp_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_flush_imem_pc", bus.imem_pc, 32'h0);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_imem_pc", bus.imem_pc, 32'h8);
    check_head("bp_hold", 32'h0);

    // Full with simultaneous push and pop
    bus.out_ready = 1'b1;
    tick();
    check_head("full_pp", 32'h4);
    check("full_pp_imem_pc", bus.imem_pc, 32'hC);
    bus.out_ready = 1'b0;
    tick();
    check_head("full_hold", 32'h4);
    check("full_hold_imem_pc", bus.imem_pc, 32'hC);
    bus.out_ready = 1'b1;
    tick();
    check_head("drain0", 32'h8);
    tick();
    check_head("drain1", 32'hC);
    check("drain_imem_pc", bus.imem_pc, 32'h14);

    // Redirect with two entries queued
    bus.out_ready = 1'b0;
    tick();
    check_head("pre_redir", 32'hC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    bus.out_ready      = 1'b1;
    tick();
    check("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    check("redir_imem_pc", bus.imem_pc, 32'h100);
    bus.redirect_valid = 1'b0;
    tick();
    check_head("redir_first", 32'h100);
    tick();
    check_head("redir_second", 32'h104);

    // Wrap through the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    check("wrap_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("wrap_imem_pc", bus.imem_pc, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    tick();
    check_head("wrap_top", 32'hFFFF_FFFC);
    check("wrap_next_imem_pc", bus.imem_pc, 32'h0);
    tick();
    check_head("wrap_zero", 32'h0);

    // Fetch disable drains the queue and holds the PC
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("dis%0d_valid", i), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("dis%0d_imem_pc", i), bus.imem_pc, 32'h4);
    end
    bus.fetch_en = 1'b1;
    tick();
    check_head("resume0", 32'h4);
    tick();
    check_head("resume1", 32'h8);

    // Asynchronous reset between edges with two entries queued
    bus.out_ready = 1'b0;
    tick();
    check_head("pre_areset", 32'h8);
    check("pre_areset_imem_pc", bus.imem_pc, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("areset_pc", bus.out_pc, 32'd0);
    check("areset_imem_pc", bus.imem_pc, 32'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check_head("post_areset", 32'h0);
    check("post_areset_imem_pc", bus.imem_pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
